hazard_sequencer: RTL

//  Hazard controller for the 5-stage MIPS pipeline. Keeps a shadow scoreboard of

---
 rtl/hazard_sequencer_pkg.sv | 33 +++
 rtl/hazard_scoreboard.sv | 39 +++
 rtl/hazard_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_sequencer_pkg.sv
// Shared types and forwarding codes for the pipeline hazard sequencer.
// Shadow entries describe one in-flight instruction in E, M or W.
package hazard_sequencer_pkg;

   localparam int REG_AW = 5;
   localparam int TYPE_W = 4;

   localparam logic [TYPE_W-1:0] FWD_NONE   = 4'h0;
   localparam logic [TYPE_W-1:0] FWD_ALUM_A = 4'h1;
   localparam logic [TYPE_W-1:0] FWD_ALUM_B = 4'h2;
   localparam logic [TYPE_W-1:0] FWD_ALUW_A = 4'h5;
   localparam logic [TYPE_W-1:0] FWD_ALUW_B = 4'h6;
   localparam logic [TYPE_W-1:0] FWD_MEMW_A = 4'h7;
   localparam logic [TYPE_W-1:0] FWD_MEMW_B = 4'h8;

   typedef struct packed {
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dst;
      logic              regwr;
      logic              load;
      logic              valid;
   } sb_entry_t;

   // $0 is hard-wired, so it never acts as a producer.
   function automatic logic is_prod(
      input sb_entry_t       e,
      input logic [REG_AW-1:0] r
   );
      return e.valid && e.regwr && (e.dst != '0) && (e.dst == r);
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// E/M/W shadow shift register; a bubble replaces the entry entering E.
// Advances every clock; the register-file holds are handled elsewhere.
module hazard_scoreboard
   import hazard_sequencer_pkg::*;
(
   input  logic      Clk,
   input  logic      Rst,
   input  sb_entry_t d_i,
   input  logic      bubble_i,
   output sb_entry_t e_o,
   output sb_entry_t m_o,
   output sb_entry_t w_o
);

   sb_entry_t e_q, m_q, w_q;
   sb_entry_t e_d;

   always_comb begin
      e_d = d_i;
      if (bubble_i) e_d = '0;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= e_q;
         w_q <= m_q;
      end
   end

   assign e_o = e_q;
   assign m_o = m_q;
   assign w_o = w_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush and forwarding-code generation for the 5-stage pipeline.
// Build with HAZARD_PERF_EN defined to add the StallCnt counter port.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic              UsesRsD,
   input  logic              UsesRtD,
   input  logic [REG_AW-1:0] WriteRegD,
   input  logic              RegWriteD,
   input  logic              MemToRegD,
   input  logic              BranchTakenE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [TYPE_W-1:0] FwdTypeE
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       StallCnt
`endif
);

   sb_entry_t d_ent, e_ent, m_ent, w_ent;
   logic a_e, a_m, b_e, b_m;
   logic load_use, dual, br, stall, bubble;
   logic [TYPE_W-1:0] fwd_d, fwd_q;
   logic unused_sb;

   assign d_ent = '{rs: RsD, rt: RtD, dst: WriteRegD,
                    regwr: RegWriteD, load: MemToRegD,
                    valid: 1'b1};

   hazard_scoreboard u_sb (
      .Clk      (Clk),
      .Rst      (Rst),
      .d_i      (d_ent),
      .bubble_i (bubble),
      .e_o      (e_ent),
      .m_o      (m_ent),
      .w_o      (w_ent)
   );

   // W writes the register file early enough that D never checks it.
   assign unused_sb = ^{e_ent.rs, e_ent.rt, m_ent.rs, m_ent.rt, w_ent};

   assign a_e = UsesRsD & is_prod(e_ent, RsD);
   assign a_m = UsesRsD & is_prod(m_ent, RsD);
   assign b_e = UsesRtD & is_prod(e_ent, RtD);
   assign b_m = UsesRtD & is_prod(m_ent, RtD);

   assign load_use = (a_e | b_e) & e_ent.load;
   assign dual     = (a_e | a_m) & (b_e | b_m);
   assign br       = BranchTakenE & ~Rst;
   assign stall    = (load_use | dual) & ~br;
   assign bubble   = stall | br;

   assign StallF = stall;
   assign StallD = stall;
   assign FlushD = br;
   assign FlushE = bubble;

   // D-side E producer sits in M at E time; D-side M producer sits in W.
   always_comb begin
      fwd_d = FWD_NONE;
      if (!bubble) begin
         priority case (1'b1)
            a_e:     fwd_d = FWD_ALUM_A;
            b_e:     fwd_d = FWD_ALUM_B;
            a_m:     fwd_d = m_ent.load ? FWD_MEMW_A : FWD_ALUW_A;
            b_m:     fwd_d = m_ent.load ? FWD_MEMW_B : FWD_ALUW_B;
            default: fwd_d = FWD_NONE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) fwd_q <= FWD_NONE;
      else     fwd_q <= fwd_d;
   end

   assign FwdTypeE = fwd_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] cnt_q, cnt_d;

   assign cnt_d = cnt_q + {31'd0, stall};

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign StallCnt = cnt_q;
`endif

endmodule
